// File: rtl/i2c_req_arbiter_if.sv
// Bundle between the on-chip requesters, the request arbiter and the shared I2C master engine.
// The arbiter takes the slave view; requesters plus master engine (or a bench) take the master view.
interface i2c_req_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [7*N_REQ-1:0] req_addr;
  logic [N_REQ-1:0]   req_rw;
  logic [3*N_REQ-1:0] req_len;
  logic [8*N_REQ-1:0] wr_data;
  logic [N_REQ-1:0]   req_grant;
  logic [N_REQ-1:0]   wr_take;
  logic [7:0]         rd_data;
  logic [N_REQ-1:0]   rd_valid;
  logic [N_REQ-1:0]   req_done;
  logic [N_REQ-1:0]   req_err;
  logic               m_start;
  logic [6:0]         m_addr;
  logic               m_rw;
  logic [2:0]         m_len;
  logic [7:0]         m_wdata;
  logic               m_abort;
  logic               m_busy;
  logic               m_byte_req;
  logic [7:0]         m_rdata;
  logic               m_rvalid;
  logic               m_done;
  logic               m_nack;

  modport slave (
    input  req_valid, req_addr, req_rw, req_len, wr_data,
    input  m_busy, m_byte_req, m_rdata, m_rvalid, m_done, m_nack,
    output req_grant, wr_take, rd_data, rd_valid, req_done, req_err,
    output m_start, m_addr, m_rw, m_len, m_wdata, m_abort
  );

  modport master (
    output req_valid, req_addr, req_rw, req_len, wr_data,
    output m_busy, m_byte_req, m_rdata, m_rvalid, m_done, m_nack,
    input  req_grant, wr_take, rd_data, rd_valid, req_done, req_err,
    input  m_start, m_addr, m_rw, m_len, m_wdata, m_abort
  );
endinterface

// File: rtl/i2c_req_arbiter.sv
// Round-robin owner selection for the single I2C master engine: launches one requester's
// transaction at a time, streams its bytes, and reports done/error back to that requester.
module i2c_req_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 200000
) (
  input  logic             clk,
  input  logic             rst,
  i2c_req_arbiter_if.slave bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ARB, START, XFER, ABORT, DONE} state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] rr_ptr, owner, sel_idx, done_idx;
  logic             sel_found, sel_bad;
  logic [2:0]       sel_len;
  logic [2:0]       cnt, cnt_n;
  logic [TO_W-1:0]  tcnt;
  logic             err_flag;
  logic             wr_hit, rd_hit, over, accept;
  logic             enter_done, fin_err;

  function automatic logic [IDX_W-1:0] rr_wrap(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return IDX_W'(s);
  endfunction

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] i);
    return (int'(i) == N_REQ - 1) ? '0 : i + IDX_W'(1);
  endfunction

  // Walk downward so the requester closest to rr_ptr is the last (winning) assignment
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[rr_wrap(rr_ptr, i)]) begin
        sel_found = 1'b1;
        sel_idx   = rr_wrap(rr_ptr, i);
      end
    end
  end

  assign sel_len  = bus.req_len[3*int'(sel_idx) +: 3];
  assign sel_bad  = (sel_len == 3'd0) || (sel_len > 3'd5);
  assign done_idx = (state == ARB) ? sel_idx : owner;

  assign wr_hit = (state == XFER) && !bus.m_rw && bus.m_byte_req;
  assign rd_hit = (state == XFER) &&  bus.m_rw && bus.m_rvalid;
  assign over   = (wr_hit || rd_hit) && (cnt >= bus.m_len);
  assign accept = (wr_hit || rd_hit) && !over;
  assign cnt_n  = accept ? cnt + 3'd1 : cnt;

  assign bus.m_wdata = (|bus.req_grant) ? bus.wr_data[8*int'(owner) +: 8] : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Completion is decided on the transition into DONE so the pulse lands in the DONE cycle
  always_comb begin
    state_n    = state;
    enter_done = 1'b0;
    fin_err    = err_flag;
    case (state)
      IDLE:  if (|bus.req_valid) state_n = ARB;
      ARB: begin
        if (!sel_found) begin
          state_n = IDLE;
        end else if (sel_bad) begin
          state_n    = DONE;
          enter_done = 1'b1;
          fin_err    = 1'b1;
        end else begin
          state_n = START;
        end
      end
      START: if (!bus.m_busy) state_n = XFER;
      XFER: begin
        if (bus.m_done) begin
          state_n    = DONE;
          enter_done = 1'b1;
          fin_err    = err_flag || over || bus.m_nack || (cnt_n != bus.m_len);
        end else if (tcnt == TO_LAST) begin
          state_n = ABORT;
        end
      end
      ABORT: begin
        if (!bus.m_busy) begin
          state_n    = DONE;
          enter_done = 1'b1;
          fin_err    = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr        <= '0;
      owner         <= '0;
      cnt           <= '0;
      tcnt          <= '0;
      err_flag      <= 1'b0;
      bus.req_grant <= '0;
      bus.wr_take   <= '0;
      bus.rd_valid  <= '0;
      bus.req_done  <= '0;
      bus.req_err   <= '0;
      bus.rd_data   <= '0;
      bus.m_start   <= 1'b0;
      bus.m_abort   <= 1'b0;
      bus.m_addr    <= '0;
      bus.m_rw      <= 1'b0;
      bus.m_len     <= '0;
    end else begin
      bus.m_start  <= 1'b0;
      bus.m_abort  <= 1'b0;
      bus.wr_take  <= '0;
      bus.rd_valid <= '0;
      bus.req_done <= '0;
      bus.req_err  <= '0;
      case (state)
        ARB: begin
          if (sel_found) begin
            owner      <= sel_idx;
            bus.m_addr <= bus.req_addr[7*int'(sel_idx) +: 7];
            bus.m_rw   <= bus.req_rw[sel_idx];
            bus.m_len  <= sel_len;
            err_flag   <= 1'b0;
            if (!sel_bad) bus.req_grant <= N_REQ'(1) << sel_idx;
          end
        end
        START: begin
          if (!bus.m_busy) begin
            bus.m_start <= 1'b1;
            cnt         <= '0;
            tcnt        <= '0;
          end
        end
        XFER: begin
          cnt <= cnt_n;
          if (tcnt != '1) tcnt <= tcnt + TO_W'(1);
          if (over) err_flag <= 1'b1;
          if (wr_hit && !over) bus.wr_take[owner] <= 1'b1;
          if (rd_hit && !over) begin
            bus.rd_data         <= bus.m_rdata;
            bus.rd_valid[owner] <= 1'b1;
          end
          // m_done on the terminal count takes priority over the abort
          if (!bus.m_done && (tcnt == TO_LAST)) begin
            bus.m_abort <= 1'b1;
            err_flag    <= 1'b1;
          end
        end
        default: ;
      endcase
      if (enter_done) begin
        bus.req_grant <= '0;
        if (fin_err) bus.req_err[done_idx]  <= 1'b1;
        else         bus.req_done[done_idx] <= 1'b1;
        rr_ptr <= rr_next(done_idx);
      end
    end
  end
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Bench for i2c_req_arbiter: table-driven single transactions, then reset, round-robin
// and timeout sequences, all checked through an ordered queue of expected output events.
`timescale 1ns/1ps
module tb_i2c_req_arbiter;
  localparam int N  = 4;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i2c_req_arbiter_if #(.N_REQ(N)) bus();
  i2c_req_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef enum {EV_GRANT, EV_START, EV_WTAKE, EV_RD, EV_ABORT, EV_DONE, EV_ERR} ev_e;
  typedef struct {ev_e kind; int idx; logic [7:0] data;} ev_t;
  typedef struct {
    int r; logic rw; logic [6:0] addr; logic [2:0] len;
    int nb; logic nack; int busy; logic [39:0] d;
  } vec_t;

  ev_t  exp_q[$];
  vec_t vecs[9];
  int   n_tests = 0, n_fail = 0, cyc = 0;
  logic [N-1:0] prev_grant = '0;
  logic [39:0]  wdat [N];
  int           wptr [N];
  int           done_cnt [N];
  logic [6:0]   r_addr [N];
  logic         r_rw [N];
  logic [2:0]   r_len [N];
  // master engine model
  bit mm_active = 0, mm_hang = 0;
  int mm_nb = 0, mm_sent = 0, mm_wait = 0, mm_abort_wait = 0, mm_ext_busy = 0;
  logic mm_rw = 0, mm_nack = 0;
  logic [39:0] mm_rd = '0;
  logic [7:0]  last_mwdata = '0;
  int t_req, t_grant, t_start, t_err, t_busy_fall, abort_gap, err_gap;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input ev_e k, input int i, input logic [7:0] d);
    exp_q.push_back('{kind: k, idx: i, data: d});
  endtask

  task automatic ev_seen(input ev_e k, input int i, input logic [7:0] d);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got %s/%0d/%0h, expected none", k.name(), i, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.idx != i || ((k == EV_WTAKE || k == EV_RD) && e.data !== d)) begin
        n_fail++;
        $display("FAIL event_order: got %s/%0d/%0h, expected %s/%0d/%0h",
                 k.name(), i, d, e.kind.name(), e.idx, e.data);
      end
    end
  endtask

  function automatic int idx_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic monitor();
    int g;
    if (bus.req_grant != prev_grant && bus.req_grant != '0) begin
      t_grant = cyc;
      chk("grant_onehot", 32'($onehot(bus.req_grant)), 1);
      ev_seen(EV_GRANT, idx_of(bus.req_grant), 8'h00);
    end
    prev_grant = bus.req_grant;
    if (bus.m_start) begin
      t_start = cyc;
      g = idx_of(bus.req_grant);
      ev_seen(EV_START, 0, 8'h00);
      if (g >= 0) chk("m_fields", {bus.m_addr, bus.m_rw, bus.m_len}, {r_addr[g], r_rw[g], r_len[g]});
      else chk("m_start_without_grant", bus.req_grant, 1);
    end
    for (int i = 0; i < N; i++) begin
      if (bus.wr_take[i]) begin
        ev_seen(EV_WTAKE, i, last_mwdata);
        wptr[i]++;
        bus.wr_data[8*i +: 8] = (wptr[i] < 5) ? wdat[i][8*wptr[i] +: 8] : 8'h00;
      end
      if (bus.rd_valid[i]) ev_seen(EV_RD, i, bus.rd_data);
    end
    if (bus.m_abort) begin
      abort_gap     = cyc - t_start;
      mm_abort_wait = 3;
      ev_seen(EV_ABORT, 0, 8'h00);
    end
    for (int i = 0; i < N; i++) begin
      if (bus.req_done[i]) ev_seen(EV_DONE, i, 8'h00);
      if (bus.req_err[i]) begin
        t_err   = cyc;
        err_gap = cyc - t_busy_fall;
        ev_seen(EV_ERR, i, 8'h00);
      end
      if (bus.req_done[i] || bus.req_err[i]) begin
        chk("grant_low_at_done", bus.req_grant, 0);
        bus.req_valid[i] = 1'b0;
        done_cnt[i]++;
      end
    end
  endtask

  task automatic master();
    bus.m_byte_req = 1'b0;
    bus.m_rvalid   = 1'b0;
    bus.m_done     = 1'b0;
    bus.m_nack     = 1'b0;
    if (bus.m_start) begin
      mm_active = 1; mm_sent = 0; mm_wait = 1; mm_rw = bus.m_rw;
    end
    if (mm_ext_busy > 0) mm_ext_busy--;
    if (mm_active) begin
      if (mm_hang) begin
        if (mm_abort_wait > 0) begin
          mm_abort_wait--;
          if (mm_abort_wait == 0) begin
            mm_active = 0; mm_hang = 0; t_busy_fall = cyc;
          end
        end
      end else if (mm_wait > 0) begin
        mm_wait--;
      end else if (mm_sent < mm_nb) begin
        if (mm_rw) begin
          bus.m_rvalid = 1'b1;
          bus.m_rdata  = mm_rd[8*mm_sent +: 8];
        end else begin
          bus.m_byte_req = 1'b1;
          last_mwdata    = bus.m_wdata;
        end
        mm_sent++;
        mm_wait = 1;
      end else begin
        bus.m_done = 1'b1;
        bus.m_nack = mm_nack;
        mm_active  = 0;
      end
    end
    bus.m_busy = mm_active || (mm_ext_busy > 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
    master();
  endtask

  task automatic post(input int r, input logic rw, input logic [6:0] a, input logic [2:0] l,
                      input logic [39:0] d);
    bus.req_addr[7*r +: 7] = a;
    bus.req_rw[r]          = rw;
    bus.req_len[3*r +: 3]  = l;
    bus.wr_data[8*r +: 8]  = d[7:0];
    wdat[r] = d; wptr[r] = 0;
    r_addr[r] = a; r_rw[r] = rw; r_len[r] = l;
    bus.req_valid[r] = 1'b1;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) step();
    if (exp_q.size() > 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: got %0d events outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) step();
  endtask

  task automatic run_vec(input vec_t v);
    bit bad;
    int n;
    bad = (v.len == 3'd0) || (v.len > 3'd5);
    t_grant = -1; t_start = -1; t_err = -1;
    post(v.r, v.rw, v.addr, v.len, v.d);
    mm_nb = v.nb; mm_nack = v.nack; mm_rd = v.d; mm_hang = 0;
    mm_ext_busy = v.busy; bus.m_busy = (v.busy > 0);
    t_req = cyc;
    if (bad) begin
      push(EV_ERR, v.r, 8'h00);
    end else begin
      push(EV_GRANT, v.r, 8'h00);
      push(EV_START, 0, 8'h00);
      n = (v.nb < int'(v.len)) ? v.nb : int'(v.len);
      for (int k = 0; k < n; k++) push(v.rw ? EV_RD : EV_WTAKE, v.r, v.d[8*k +: 8]);
      push((v.nack || v.nb != int'(v.len)) ? EV_ERR : EV_DONE, v.r, 8'h00);
    end
    drain(400);
    if (bad) begin
      chk("badlen_err_latency", t_err - t_req, 2);
    end else begin
      chk("grant_latency", t_grant - t_req, 2);
      chk("start_latency", t_start - t_req, (v.busy + 1 > 3) ? v.busy + 1 : 3);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 1'b0, 7'h10, 3'd5, 5, 1'b0, 0, 40'h01_02_04_08_00};
    vecs[1] = '{2, 1'b1, 7'h2A, 3'd3, 3, 1'b0, 0, 40'h00_00_F0_55_AA};
    vecs[2] = '{1, 1'b0, 7'h33, 3'd2, 2, 1'b1, 0, 40'h00_00_00_C3_3C};
    vecs[3] = '{3, 1'b0, 7'h44, 3'd0, 0, 1'b0, 0, 40'h00_00_00_00_5A};
    vecs[4] = '{0, 1'b0, 7'h10, 3'd5, 6, 1'b0, 0, 40'h11_22_33_44_55};
    vecs[5] = '{1, 1'b1, 7'h51, 3'd4, 3, 1'b0, 0, 40'h00_9A_BC_DE_F0};
    vecs[6] = '{3, 1'b0, 7'h7F, 3'd1, 1, 1'b0, 6, 40'h00_00_00_00_A5};
    vecs[7] = '{2, 1'b0, 7'h01, 3'd6, 0, 1'b0, 0, 40'h00_00_00_00_00};
    vecs[8] = '{1, 1'b1, 7'h62, 3'd2, 3, 1'b0, 0, 40'h00_00_77_66_99};

    rst = 1'b1;
    bus.req_valid = '0; bus.req_addr = '0; bus.req_rw = '0; bus.req_len = '0; bus.wr_data = '0;
    bus.m_busy = 0; bus.m_byte_req = 0; bus.m_rdata = '0; bus.m_rvalid = 0; bus.m_done = 0; bus.m_nack = 0;
    for (int i = 0; i < N; i++) begin
      wdat[i] = '0; wptr[i] = 0; done_cnt[i] = 0; r_addr[i] = '0; r_rw[i] = 0; r_len[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state_ctl", {bus.req_grant, bus.wr_take, bus.rd_valid, bus.req_done, bus.req_err,
                            bus.m_start, bus.m_abort, bus.m_rw, bus.m_len}, 0);
    chk("reset_state_dat", {bus.m_addr, bus.rd_data, bus.m_wdata}, 0);
    rst = 1'b0;
    repeat (2) step();

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // asynchronous reset in the middle of a write
    post(2, 1'b0, 7'h2B, 3'd5, 40'h05_04_03_02_01);
    mm_nb = 5; mm_nack = 0; mm_hang = 0; mm_ext_busy = 0;
    push(EV_GRANT, 2, 8'h00); push(EV_START, 0, 8'h00);
    push(EV_WTAKE, 2, 8'h01); push(EV_WTAKE, 2, 8'h02);
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) step();
    chk("pre_reset_progress", exp_q.size(), 0);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_ctl", {bus.req_grant, bus.wr_take, bus.rd_valid, bus.req_done, bus.req_err,
                            bus.m_start, bus.m_abort, bus.m_rw, bus.m_len}, 0);
    chk("async_reset_dat", {bus.m_addr, bus.rd_data, bus.m_wdata}, 0);
    bus.req_valid = '0; bus.m_byte_req = 0; bus.m_rvalid = 0; bus.m_done = 0; bus.m_busy = 0;
    mm_active = 0; mm_hang = 0; mm_ext_busy = 0; mm_abort_wait = 0;
    exp_q.delete();
    prev_grant = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) step();

    // round-robin: all four together, twice; order must restart at requester 0
    for (int i = 0; i < N; i++) done_cnt[i] = 0;
    mm_nb = 1; mm_nack = 0;
    for (int rnd = 0; rnd < 2; rnd++) begin
      for (int r = 0; r < N; r++) begin
        logic [7:0] b;
        b = 8'h10 + 8'(r) + 8'(16 * rnd);
        post(r, 1'b0, 7'h20 + 7'(r), 3'd1, 40'(b));
        push(EV_GRANT, r, 8'h00); push(EV_START, 0, 8'h00);
        push(EV_WTAKE, r, b);     push(EV_DONE, r, 8'h00);
      end
      drain(400);
    end
    for (int r = 0; r < N; r++) chk($sformatf("rr_done_count_%0d", r), done_cnt[r], 2);

    // timeout on requester 1 while requester 3 waits
    t_busy_fall = -1000; abort_gap = -1; err_gap = -1;
    post(1, 1'b0, 7'h3C, 3'd2, 40'h00_00_00_99_88);
    post(3, 1'b0, 7'h3D, 3'd1, 40'h00_00_00_00_C7);
    mm_nb = 1; mm_nack = 0; mm_hang = 1;
    push(EV_GRANT, 1, 8'h00); push(EV_START, 0, 8'h00); push(EV_ABORT, 0, 8'h00);
    push(EV_ERR, 1, 8'h00);
    push(EV_GRANT, 3, 8'h00); push(EV_START, 0, 8'h00); push(EV_WTAKE, 3, 8'hC7);
    push(EV_DONE, 3, 8'h00);
    drain(600);
    chk("abort_after_start", abort_gap, TO);
    chk("err_after_busy_fall", err_gap, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
